gpca_core: RTL and testbench

- General-purpose computational array (GPCA) built from 5 rows of controlled add/subtract cells.
- Operation is selected by X and the B/C control words:
  - multiply-accumulate,
  - square-accumulate,
  - restoring division,
  - integer square root.
- Arithmetic is combinational through the array, followed by a single registered output stage.
- Used as a standalone arithmetic leaf block inside the datapath.

---
 rtl/gpca_pkg.sv | 21 ++
 rtl/gpca_if.sv | 16 +
 rtl/gpca_row.sv | 41 ++++
 rtl/gpca_core.sv | 92 +++++++++
 tb/tb_gpca_core.sv | 128 ++++++++++++
 5 files changed

// File: rtl/gpca_pkg.sv
// rtl/gpca_pkg.sv - shared widths, mode encoding and row control type for the GPCA
package gpca_pkg;

    localparam int P_W  = 5;
    localparam int BC_W = 7;
    localparam int A_W  = 10;
    localparam int F_W  = 5;
    localparam int S_W  = 11;
    localparam int SH_W = 4;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Row behaviour: pass-through, add, or trial-subtract with restore on negative
    typedef enum logic [1:0] {
        ROW_PASS = 2'd0,
        ROW_ADD  = 2'd1,
        ROW_SUB  = 2'd2
    } row_op_e;

endpackage

// File: rtl/gpca_if.sv
// rtl/gpca_if.sv - operand/result bundle of the GPCA (bit 1 is the MSB of every word)
interface gpca_if;
    import gpca_pkg::*;

    logic           X;
    logic [1:P_W]   P;
    logic [1:BC_W]  B;
    logic [1:BC_W]  C;
    logic [1:A_W]   A;
    logic [1:F_W]   F;
    logic [1:S_W]   S;

    modport master (output X, P, B, C, A, input F, S);
    modport slave  (input X, P, B, C, A, output F, S);

endinterface

// File: rtl/gpca_row.sv
// rtl/gpca_row.sv - one array row of 11-bit controlled add/subtract cells
module gpca_row
    import gpca_pkg::*;
(
    input  logic [S_W-1:0]  acc_in,
    input  logic [S_W-1:0]  operand,
    input  logic [SH_W-1:0] shift,
    input  row_op_e         op,
    output logic [S_W-1:0]  acc_out,
    output logic            flag
);

    logic [S_W-1:0] shifted;
    logic [S_W:0]   sum;
    logic [S_W:0]   diff;

    // flag is the carry out for ROW_ADD and the borrow (negative trial) for ROW_SUB
    always_comb begin
        shifted = operand << shift;
        sum     = {1'b0, acc_in} + {1'b0, shifted};
        diff    = {1'b0, acc_in} - {1'b0, shifted};
        acc_out = acc_in;
        flag    = 1'b0;
        case (op)
            ROW_ADD: begin
                acc_out = sum[S_W-1:0];
                flag    = sum[S_W];
            end
            ROW_SUB: begin
                flag = diff[S_W];
                if (!diff[S_W]) begin
                    acc_out = diff[S_W-1:0];
                end
            end
            default: begin
                acc_out = acc_in;
            end
        endcase
    end

endmodule

// File: rtl/gpca_core.sv
// rtl/gpca_core.sv - 5-row add/subtract array: MAC, square-accumulate, divide, square root
module gpca_core
    import gpca_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    gpca_if.slave  bus
);

    logic [P_W-1:0]  p_v;
    logic [BC_W-1:0] b_v;
    logic [BC_W-1:0] c_v;
    logic [A_W-1:0]  a_v;
    logic            mode;
    logic            sq;
    logic [BC_W-1:0] mcand;

    assign p_v   = bus.P;
    assign b_v   = bus.B;
    assign c_v   = bus.C;
    assign a_v   = bus.A;
    assign mode  = bus.X;
    assign sq    = |(c_v & ~b_v);
    assign mcand = sq ? {{(BC_W-P_W){1'b0}}, p_v} : b_v;

    // acc carries the running sum / partial remainder down the rows;
    // root collects one result bit per row (quotient or root, MSB first)
    logic [S_W-1:0] acc  [0:P_W];
    logic [P_W-1:0] root [0:P_W];

    assign acc[0]  = {{(S_W-A_W){1'b0}}, a_v};
    assign root[0] = '0;

    for (genvar i = 0; i < P_W; i++) begin : g_row
        localparam int K = P_W - 1 - i;

        logic [S_W-1:0]  opnd;
        logic [SH_W-1:0] sh;
        row_op_e         op;
        logic            flag;

        // Row i operand select: shifted multiplicand, shifted divisor, or the
        // root trial (4r+1)<<2K where r is the root found by the rows above
        always_comb begin
            opnd = '0;
            sh   = '0;
            op   = ROW_PASS;
            if (mode == MODE_MUL) begin
                opnd = {{(S_W-BC_W){1'b0}}, mcand};
                sh   = SH_W'(K);
                op   = p_v[K] ? ROW_ADD : ROW_PASS;
            end else if (!sq) begin
                opnd = {{(S_W-BC_W){1'b0}}, b_v};
                sh   = SH_W'(K);
                op   = ROW_SUB;
            end else begin
                opnd = {{(S_W-P_W-2){1'b0}}, root[i], 2'b01};
                sh   = SH_W'(2 * K);
                op   = ROW_SUB;
            end
        end

        gpca_row u_row (
            .acc_in  (acc[i]),
            .operand (opnd),
            .shift   (sh),
            .op      (op),
            .acc_out (acc[i+1]),
            .flag    (flag)
        );

        assign root[i+1] = {root[i][P_W-2:0], ~flag};
    end

    logic [F_W-1:0] f_q;
    logic [S_W-1:0] s_q;

    // Single output register; F only carries a result in divide/root mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q <= '0;
            s_q <= '0;
        end else begin
            f_q <= (mode == MODE_DIV) ? root[P_W] : '0;
            s_q <= acc[P_W];
        end
    end

    assign bus.F = f_q;
    assign bus.S = s_q;

endmodule

// File: tb/tb_gpca_core.sv
// tb/tb_gpca_core.sv - self-checking bench for gpca_core
module tb_gpca_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    gpca_if bus ();

    gpca_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic x, input logic [4:0] p, input logic [6:0] b,
                                  input logic [6:0] c, input logic [9:0] a,
                                  output logic [4:0] ef, output logic [10:0] es);
        int sq, q, r;
        sq = ((c & ~b) != 7'd0) ? 1 : 0;
        if (x == 1'b0) begin
            ef = 5'd0;
            if (sq == 1) es = 11'((int'(a) + int'(p) * int'(p)) % 2048);
            else         es = 11'((int'(a) + int'(p) * int'(b)) % 2048);
        end else if (sq == 0) begin
            if (b == 7'd0) q = 31;
            else           q = int'(a) / int'(b);
            if (q > 31) q = 31;
            ef = 5'(q);
            es = 11'(int'(a) - q * int'(b));
        end else begin
            r = 0;
            while ((r + 1) * (r + 1) <= int'(a)) r++;
            ef = 5'(r);
            es = 11'(int'(a) - r * r);
        end
    endfunction

    task automatic drive(input logic x, input logic [4:0] p, input logic [6:0] b,
                         input logic [6:0] c, input logic [9:0] a);
        bus.X = x;
        bus.P = p;
        bus.B = b;
        bus.C = c;
        bus.A = a;
    endtask

    task automatic check(input string tag, input logic [4:0] ef, input logic [10:0] es);
        checks++;
        assert (bus.F === ef && bus.S === es)
        else begin
            failures++;
            $error("FAIL %s: got F=%0d S=%0d, expected F=%0d S=%0d", tag, bus.F, bus.S, ef, es);
        end
    endtask

    task automatic op(input string tag, input logic x, input logic [4:0] p, input logic [6:0] b,
                      input logic [6:0] c, input logic [9:0] a,
                      input logic [4:0] ef, input logic [10:0] es);
        drive(x, p, b, c, a);
        @(posedge clk);
        #1;
        check(tag, ef, es);
    endtask

    initial begin
        logic        x;
        logic [4:0]  p, ef;
        logic [6:0]  b, c;
        logic [9:0]  a;
        logic [10:0] es;

        drive(1'b0, 5'd7, 7'd55, 7'd3, 10'd999);
        #1 rst_n = 1'b0;
        #1 check("reset_async", 5'd0, 11'd0);
        @(posedge clk);
        #1 check("reset_hold", 5'd0, 11'd0);

        drive(1'b0, 5'd0, 7'd0, 7'd0, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("reset_release", 5'd0, 11'd0);

        op("mul",        1'b0, 5'd5,  7'b1110000, 7'b1110000, 10'd0,    5'd0,  11'd560);
        op("square",     1'b0, 5'd5,  7'b0011111, 7'b0100000, 10'd0,    5'd0,  11'd25);
        op("mul_wrap",   1'b0, 5'd31, 7'b1111111, 7'b1111111, 10'd1023, 5'd0,  11'd864);
        op("sq_max",     1'b0, 5'd31, 7'b0011111, 7'b0100000, 10'd1023, 5'd0,  11'd1984);
        op("sqrt25",     1'b1, 5'd0,  7'b0011111, 7'b0100000, 10'd25,   5'd5,  11'd0);
        op("sqrt1023",   1'b1, 5'd9,  7'b0011111, 7'b0100000, 10'd1023, 5'd31, 11'd62);
        op("sqrt0",      1'b1, 5'd0,  7'b0011111, 7'b0100000, 10'd0,    5'd0,  11'd0);
        op("div784_80",  1'b1, 5'd0,  7'd80,      7'd80,      10'd784,  5'd9,  11'd64);
        op("div_by0",    1'b1, 5'd0,  7'd0,       7'd0,       10'd100,  5'd31, 11'd100);
        op("div_sat",    1'b1, 5'd17, 7'd3,       7'd3,       10'd1000, 5'd31, 11'd907);
        op("div_exact",  1'b1, 5'd0,  7'd127,     7'd0,       10'd1016, 5'd8,  11'd0);

        // Back-to-back random operations, a new one every cycle
        for (int n = 0; n < 60; n++) begin
            x = 1'($urandom);
            p = 5'($urandom);
            b = 7'($urandom);
            c = ($urandom_range(0, 1) == 0) ? b : 7'($urandom);
            a = 10'($urandom);
            if (n % 8 == 0) a = 10'd1023;
            if (n % 11 == 0) b = 7'd0;
            model(x, p, b, c, a, ef, es);
            op("random", x, p, b, c, a, ef, es);
        end

        // Reset in the middle of a stream clears outputs without waiting for a clock
        op("pre_reset", 1'b0, 5'd5, 7'b1110000, 7'b1110000, 10'd3, 5'd0, 11'd563);
        #2 rst_n = 1'b0;
        #1 check("mid_reset", 5'd0, 11'd0);
        @(posedge clk);
        #1 check("mid_reset_hold", 5'd0, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset", 5'd0, 11'd563);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
